// File: rtl/key_conditioner_if.sv
// Signal bundle between the raw board inputs and the conditioned counter controls.
// The master drives the raw KEY/sw lines; the slave (key_conditioner) returns the conditioned set.
interface key_conditioner_if;
  logic [3:0]  KEY;
  logic [17:0] sw;
  logic [17:0] sw_sync;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic        cnt_clear;
  logic        cnt_run;
  logic        cnt_dir;
  logic        cnt_fast;
  logic        cnt_hold;

  modport master (
    output KEY, sw,
    input  sw_sync, key_level, key_press,
    input  cnt_clear, cnt_run, cnt_dir, cnt_fast, cnt_hold
  );

  modport slave (
    input  KEY, sw,
    output sw_sync, key_level, key_press,
    output cnt_clear, cnt_run, cnt_dir, cnt_fast, cnt_hold
  );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises switches/pushbuttons, debounces each key independently and derives
// the BCD counter's clear / run / direction / fast / hold controls.
//
// state       | meaning
// IDLE        | key released, waiting for a pressed sample
// ARM_PRESS   | pressed seen, counting stable pressed cycles
// PRESSED     | press accepted, key_level high
// ARM_RELEASE | released seen, counting stable released cycles (level still high)
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  key_conditioner_if.slave io
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_TC  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_ONE = DW'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } key_state_e;

  logic [3:0]  key_s1, key_s2;
  logic [17:0] sw_s1, sw_s2;
  logic [3:0]  pressed;
  logic [3:0]  level_w;
  logic [3:0]  press_w;
  logic        run_q;

  // Keys idle released (high) so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= io.KEY;
      key_s2 <= key_s1;
      sw_s1  <= io.sw;
      sw_s2  <= sw_s1;
    end
  end

  assign pressed = ~key_s2;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_state_e    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          press_d;
    logic          level_r, press_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        level_r <= 1'b0;
        press_r <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        level_r <= (state_d == PRESSED) || (state_d == ARM_RELEASE);
        press_r <= press_d;
      end
    end

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      press_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pressed[i]) begin
            state_d = ARM_PRESS;
            dcnt_d  = DCNT_ONE;
          end
        end
        ARM_PRESS: begin
          if (!pressed[i]) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_TC) begin
            state_d = PRESSED;
            dcnt_d  = '0;
            press_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end
        PRESSED: begin
          if (!pressed[i]) begin
            state_d = ARM_RELEASE;
            dcnt_d  = DCNT_ONE;
          end
        end
        ARM_RELEASE: begin
          // A bounce back to pressed resumes PRESSED without a new pulse.
          if (pressed[i]) begin
            state_d = PRESSED;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_TC) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          dcnt_d  = '0;
        end
      endcase
    end

    assign level_w[i] = level_r;
    assign press_w[i] = press_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b1;
    end else if (press_w[1]) begin
      run_q <= ~run_q;
    end
  end

  assign io.sw_sync   = sw_s2;
  assign io.key_level = level_w;
  assign io.key_press = press_w;
  assign io.cnt_clear = press_w[0];
  assign io.cnt_run   = run_q;
  assign io.cnt_dir   = sw_s2[0];
  assign io.cnt_fast  = sw_s2[1];
  assign io.cnt_hold  = ~run_q | sw_s2[2];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboarded bench for key_conditioner: a run-length debounce model predicts press
// events into a queue and the full output set each cycle; a negedge monitor compares.
module tb_key_conditioner;

  localparam int D = 4;

  logic clk;
  logic rst;
  key_conditioner_if kif ();

  key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .io  (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } press_t;

  press_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit model_ok = 1'b0;

  // Reference model: a level flips once the synchronised key has disagreed with it
  // for D+1 consecutive samples; every 0->1 flip is a press event.
  logic [3:0]  m_k1, m_k2;
  logic [17:0] m_s1, m_s2;
  logic [3:0]  m_level, m_press;
  logic        m_run;
  logic        m_p;
  int          run_len [4];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_k1 = 4'hF; m_k2 = 4'hF;
      m_s1 = '0;   m_s2 = '0;
      m_level = '0; m_press = '0;
      m_run = 1'b1;
      for (int i = 0; i < 4; i++) run_len[i] = 0;
      model_ok = 1'b1;
    end else begin
      if (m_press[1]) m_run = ~m_run;
      for (int i = 0; i < 4; i++) begin
        m_p = ~m_k2[i];
        m_press[i] = 1'b0;
        if (m_p != m_level[i]) begin
          run_len[i]++;
          if (run_len[i] == D + 1) begin
            m_level[i] = m_p;
            run_len[i] = 0;
            m_press[i] = m_p;
          end
        end else begin
          run_len[i] = 0;
        end
      end
      if (m_press != 4'h0) exp_q.push_back('{cyc: cyc, mask: m_press});
      m_k2 = m_k1; m_k1 = kif.KEY;
      m_s2 = m_s1; m_s1 = kif.sw;
    end
  end

  logic [30:0] got_vec, exp_vec;
  press_t      e;

  always @(negedge clk) begin
    if (model_ok) begin
      got_vec = {kif.sw_sync, kif.key_level, kif.key_press, kif.cnt_clear, kif.cnt_run,
                 kif.cnt_dir, kif.cnt_fast, kif.cnt_hold};
      exp_vec = {m_s2, m_level, m_press, m_press[0], m_run,
                 m_s2[0], m_s2[1], ~m_run | m_s2[2]};
      n_chk++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (kif.key_press !== 4'h0) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL press_unexpected cyc=%0d got=%b exp=none", cyc, kif.key_press);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.mask !== kif.key_press) begin
            n_fail++;
            $display("FAIL press_event cyc=%0d got=%b exp=%b@%0d", cyc, kif.key_press, e.mask, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL press_missing cyc=%0d got=0000 exp=%b@%0d", cyc, exp_q[0].mask, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_key(input int k, input int hold, input int gap);
    kif.KEY[k] = 1'b0;
    step(hold);
    kif.KEY[k] = 1'b1;
    step(gap);
  endtask

  int hold_left [4];
  int p1_count;

  initial begin
    rst = 1'b1;
    kif.KEY = 4'hF;
    kif.sw  = '0;
    step(3);
    rst = 1'b0;
    step(5);

    // clean press and release of KEY[0]
    press_key(0, 20, 15);

    // bounce on KEY[1]: low 2, high 1, then held
    kif.KEY[1] = 1'b0; step(2);
    kif.KEY[1] = 1'b1; step(1);
    press_key(1, 15, 15);

    // two toggles with hold forced by sw[2]
    kif.sw[2] = 1'b1; step(3);
    press_key(1, 10, 10);
    press_key(1, 10, 10);
    kif.sw[2] = 1'b0; step(3);

    // simultaneous KEY[0]/KEY[1]
    kif.KEY[1:0] = 2'b00; step(10);
    kif.KEY[1:0] = 2'b11; step(10);

    // reset part-way through a press debounce, key kept held
    kif.KEY[0] = 1'b0; step(5);
    rst = 1'b1; step(2);
    rst = 1'b0; step(12);
    kif.KEY[0] = 1'b1; step(12);

    // release bounce on KEY[2]
    kif.KEY[2] = 1'b0; step(10);
    kif.KEY[2] = 1'b1; step(2);
    press_key(2, 3, 12);

    // switches one at a time
    for (int b = 0; b < 3; b++) begin
      kif.sw[b] = 1'b1; step(5);
      kif.sw[b] = 1'b0; step(5);
    end

    // randomized: per-key segments of random length (short ones bounce), random switches, rare resets
    for (int i = 0; i < 4; i++) hold_left[i] = $urandom_range(1, 12);
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < 4; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          kif.KEY[i] = ~kif.KEY[i];
          hold_left[i] = $urandom_range(1, 12);
        end
      end
      if ($urandom_range(0, 15) == 0) kif.sw = 18'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    kif.KEY = 4'hF;
    step(20);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL press_drain got=%0d_left exp=0_left", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // pulses on key 1 are counted for visibility only; correctness comes from the scoreboard
  initial p1_count = 0;
  always @(negedge clk) if (kif.key_press[1] === 1'b1) p1_count++;

endmodule
